div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Sequencing controller for a multi-cycle 32/32 radix-2 non-restoring divider serving MIPS DIV/DIVU.
- Accepts one divide request from the EX stage and converts signed operands to magnitudes.
- Runs the iterative core, sign-corrects the results and writes the HI (remainder) and LO (quotient) registers.
- Drives a pipeline stall while busy and supports cancellation by pipeline flush (exception/branch squash).

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported; all latencies below assume it.
- ITER, 32, iterations of the core; must equal WIDTH.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- div_req  in  1  request a divide; accepted only when busy=0 and flush=0
- div_signed  in  1  1=DIV (two's complement), 0=DIVU; sampled at accept
- div_a  in  32  dividend; sampled at accept
- div_b  in  32  divisor; sampled at accept
- flush  in  1  cancel any in-flight divide
- busy  out  1  divider occupied; pipeline must stall dependent HI/LO reads
- result_valid  out  1  one-cycle pulse: HI/LO updated this cycle
- div_by_zero  out  1  qualifies result_valid: divisor was zero
- hi  out  32  remainder register
- lo  out  32  quotient register

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE; busy=0, result_valid=0, div_by_zero=0, hi=0, lo=0. The core is also reset.
- Asserting resetn mid-operation discards the operation; hi/lo return to 0.
- State machine: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - On div_req & ~flush, latch div_signed, div_a, div_b and go to PREP.
  - div_req & flush together: flush wins, request not accepted.
- PREP (1 cycle):
  - Compute magnitudes |a| and |b|. A magnitude is the operand's absolute value when signed and the MSB is set, otherwise the operand unchanged.
  - Record neg_q = signed & (a[31]^b[31]) and neg_r = signed & a[31].
  - If b==0: go to DONE with lo=32'hFFFFFFFF, hi=div_a (raw dividend) and div_by_zero=1.
  - Otherwise pulse core start and go to RUN.
- RUN: wait exactly ITER cycles for the core; on the core's done pulse, go to FIX.
- FIX (1 cycle):
  - lo = neg_q ? -q : q.
  - hi = neg_r ? -r : r. The core delivers an already-restored, non-negative remainder.
  - Go to DONE.
- DONE (1 cycle): result_valid=1 and busy=0, then go to IDLE. A new div_req is accepted in DONE (back-to-back operation).
- busy = 1 in PREP, RUN and FIX; 0 in IDLE and DONE.
- Latency, counted from the accepting edge to the edge after which result_valid is high:
  - normal: 1 (PREP) + 32 (RUN) + 1 (FIX) + 1 = 35 edges.
  - divide-by-zero: 2 edges.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: |a|=0x80000000, |b|=1, giving q=0x80000000 and r=0. After negation lo=0x80000000, hi=0. No exception is raised.
- flush in PREP, RUN or FIX:
  - Next state is IDLE; the core is cancelled (its count and busy cleared).
  - hi/lo keep their previous values; no result_valid.
- flush in DONE: has no effect, because the result is already committed.
- hi/lo change only in FIX or in the divide-by-zero path. div_by_zero is held until the next result_valid.
- Requests while busy=1 are ignored; the requester holds div_req until accepted.

Decomposition:
- Shared package div_pkg:
  - state encoding constants (IDLE, PREP, RUN, FIX, DONE)
  - DIV_WIDTH=32, DIV_ITER=32
  - DIV0_QUOT=32'hFFFFFFFF
- Sub-module div_core_u32, the unsigned iterative non-restoring 32/32 core:
  - inputs: start, cancel, a, b
  - outputs: q, r (restored), busy, done (1-cycle pulse after 32 iterations)
- div_ctrl owns the FSM, sign handling, HI/LO registers and flush logic.

Test Plan:
- DIVU 100/7 -> result_valid exactly 35 edges after accept; lo=14, hi=2, div_by_zero=0.
- DIV -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 7/-2 -> lo=-3, hi=1.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU of the same operands -> lo=0, hi=0x80000000.
- DIVU 1234/0 -> result_valid 2 edges after accept; lo=0xFFFFFFFF, hi=1234, div_by_zero=1.
- Start 50/5, assert flush at RUN cycle 10 -> busy=0 the next cycle, no result_valid, hi/lo unchanged. A new request 9/3 then gives lo=3, hi=0.
- Mid-RUN resetn pulse -> all outputs 0 immediately. Back-to-back test: div_req held through DONE -> second request accepted in the DONE cycle; two result_valid pulses 35 edges apart.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the MIPS DIV/DIVU sequencer.
// Includes the single non-restoring iteration step used by the core.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } div_state_e;

  // One radix-2 non-restoring step: returns {rem[32:0], quo[31:0]}.
  function automatic logic [64:0] nr_step(
    input logic [32:0] rem,
    input logic [31:0] quo,
    input logic [31:0] dvs
  );
    logic [32:0] sh;
    logic [32:0] nr;
    sh = {rem[31:0], quo[31]};
    if (rem[32]) nr = sh + {1'b0, dvs};
    else         nr = sh - {1'b0, dvs};
    return {nr, quo[30:0], ~nr[32]};
  endfunction

endpackage

// File: rtl/div_core_u32.sv
// Unsigned 32/32 non-restoring divide core, one bit per cycle.
// The first iteration runs on the start edge; done pulses after the last.
module div_core_u32
  import div_pkg::*;
#(
  parameter int ITER = DIV_ITER
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        busy,
  output logic        done
);

  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [64:0] step;

  // Iteration registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Load on start, iterate while busy, pulse done on the final step.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    step   = '0;
    if (cancel) begin
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (start) begin
      step   = nr_step(33'd0, a, b);
      rem_d  = step[64:32];
      quo_d  = step[31:0];
      dvs_d  = b;
      cnt_d  = 6'(ITER - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      step  = nr_step(rem_q, quo_q, dvs_q);
      rem_d = step[64:32];
      quo_d = step[31:0];
      cnt_d = cnt_q - 6'd1;
      if (cnt_q == 6'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Final restore of a negative partial remainder.
  always_comb begin
    q    = quo_q;
    r    = rem_q[32] ? rem_q[31:0] + dvs_q : rem_q[31:0];
    busy = busy_q;
    done = done_q;
  end

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: sign handling, HI/LO registers, stall and flush.
// Magnitudes go to the unsigned core; results are sign-corrected in FIX.
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITER  = DIV_ITER
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             div_req,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_a,
  input  logic [WIDTH-1:0] div_b,
  input  logic             flush,
  output logic             busy,
  output logic             result_valid,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  div_state_e  state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        dz_q, dz_d;

  logic [31:0] mag_a, mag_b;
  logic [31:0] core_q, core_r;
  logic        neg_q, neg_r, b_zero;
  logic        core_start, core_cancel;
  logic        core_busy, core_done;
  logic        accept, busy_s;

  // State and architectural registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  // Next state; flush wins over everything except a committed DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_PREP;
      S_PREP: begin
        if (flush)       state_d = S_IDLE;
        else if (b_zero) state_d = S_DONE;
        else             state_d = S_RUN;
      end
      S_RUN: begin
        if (flush)          state_d = S_IDLE;
        else if (core_done) state_d = S_FIX;
      end
      S_FIX: begin
        if (flush) state_d = S_IDLE;
        else       state_d = S_DONE;
      end
      S_DONE: begin
        if (accept) state_d = S_PREP;
        else        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, sign correction and HI/LO update.
  always_comb begin
    busy_s = (state_q == S_PREP) || (state_q == S_RUN) ||
             (state_q == S_FIX);
    accept = div_req && !flush &&
             ((state_q == S_IDLE) || (state_q == S_DONE));
    mag_a  = (sgn_q && a_q[31]) ? -a_q : a_q;
    mag_b  = (sgn_q && b_q[31]) ? -b_q : b_q;
    neg_q  = sgn_q && (a_q[31] ^ b_q[31]);
    neg_r  = sgn_q && a_q[31];
    b_zero = (b_q == 32'd0);

    core_start  = (state_q == S_PREP) && !flush && !b_zero;
    core_cancel = flush && busy_s;

    a_d   = a_q;
    b_d   = b_q;
    sgn_d = sgn_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    dz_d  = dz_q;
    if (accept) begin
      a_d   = div_a;
      b_d   = div_b;
      sgn_d = div_signed;
    end
    if ((state_q == S_PREP) && !flush && b_zero) begin
      lo_d = DIV0_QUOT;
      hi_d = a_q;
      dz_d = 1'b1;
    end
    if ((state_q == S_FIX) && !flush) begin
      lo_d = neg_q ? -core_q : core_q;
      hi_d = neg_r ? -core_r : core_r;
      dz_d = 1'b0;
    end
  end

  // Outputs.
  always_comb begin
    busy         = busy_s;
    result_valid = (state_q == S_DONE);
    div_by_zero  = dz_q;
    hi           = hi_q;
    lo           = lo_q;
  end

  div_core_u32 #(
    .ITER (ITER)
  ) u_core (
    .clock  (clock),
    .resetn (resetn),
    .start  (core_start),
    .cancel (core_cancel),
    .a      (mag_a),
    .b      (mag_b),
    .q      (core_q),
    .r      (core_r),
    .busy   (core_busy),
    .done   (core_done)
  );

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl.
// Latency counts the accepting edge as edge 1.
module tb_div_ctrl;

  logic        clock;
  logic        resetn;
  logic        div_req;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        flush;
  logic        busy;
  logic        result_valid;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int errs;
  int chks;

  div_ctrl dut (
    .clock        (clock),
    .resetn       (resetn),
    .div_req      (div_req),
    .div_signed   (div_signed),
    .div_a        (div_a),
    .div_b        (div_b),
    .flush        (flush),
    .busy         (busy),
    .result_valid (result_valid),
    .div_by_zero  (div_by_zero),
    .hi           (hi),
    .lo           (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    chks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Counts edges until result_valid is seen; n starts at 1.
  task automatic wait_rv(output int n);
    n = 1;
    while (!result_valid && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic run_div(
    input string       tag,
    input logic        sg,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] xlo,
    input logic [31:0] xhi,
    input logic        xdz,
    input int          xlat
  );
    int n;
    div_req    = 1'b1;
    div_signed = sg;
    div_a      = a;
    div_b      = b;
    @(posedge clock);
    #1;
    div_req = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    wait_rv(n);
    chk({tag, ".lat"}, n, xlat);
    chk({tag, ".lo"}, lo, xlo);
    chk({tag, ".hi"}, hi, xhi);
    chk({tag, ".dz"}, 32'(div_by_zero), 32'(xdz));
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    int rv_seen;
    errs       = 0;
    chks       = 0;
    resetn     = 1'b0;
    div_req    = 1'b0;
    div_signed = 1'b0;
    div_a      = '0;
    div_b      = '0;
    flush      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.rv", 32'(result_valid), 32'd0);
    chk("rst.dz", 32'(div_by_zero), 32'd0);
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    run_div("u100_7", 1'b0, 32'd100, 32'd7,
            32'd14, 32'd2, 1'b0, 35);
    run_div("sm7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 35);
    run_div("s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
            32'hFFFF_FFFD, 32'd1, 1'b0, 35);
    run_div("sovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 32'd0, 1'b0, 35);
    run_div("uovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
            32'd0, 32'h8000_0000, 1'b0, 35);
    run_div("udiv0", 1'b0, 32'd1234, 32'd0,
            32'hFFFF_FFFF, 32'd1234, 1'b1, 2);
    chk("dz.held", 32'(div_by_zero), 32'd1);

    // flush in RUN: hi/lo keep div0 results
    div_req = 1'b1;
    div_a   = 32'd50;
    div_b   = 32'd5;
    @(posedge clock);
    #1;
    div_req = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("fl.busy", 32'(busy), 32'd0);
    rv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid) rv_seen++;
      @(posedge clock);
      #1;
    end
    chk("fl.norv", rv_seen, 0);
    chk("fl.lo", lo, 32'hFFFF_FFFF);
    chk("fl.hi", hi, 32'd1234);
    run_div("u9_3", 1'b0, 32'd9, 32'd3,
            32'd3, 32'd0, 1'b0, 35);

    // flush together with request: not accepted
    div_req = 1'b1;
    flush   = 1'b1;
    @(posedge clock);
    #1;
    div_req = 1'b0;
    flush   = 1'b0;
    chk("flreq.busy", 32'(busy), 32'd0);

    // mid-RUN reset
    div_req = 1'b1;
    div_a   = 32'd77;
    div_b   = 32'd5;
    @(posedge clock);
    #1;
    div_req = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.hi", hi, 32'd0);
    chk("mrst.lo", lo, 32'd0);
    chk("mrst.rv", 32'(result_valid), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // back-to-back: request held through DONE
    div_req    = 1'b1;
    div_signed = 1'b0;
    div_a      = 32'd100;
    div_b      = 32'd7;
    @(posedge clock);
    #1;
    wait_rv(n);
    chk("b2b.lat1", n, 35);
    chk("b2b.lo1", lo, 32'd14);
    div_a = 32'd9;
    div_b = 32'd3;
    @(posedge clock);
    #1;
    div_req = 1'b0;
    chk("b2b.busy", 32'(busy), 32'd1);
    wait_rv(n);
    chk("b2b.lat2", n, 35);
    chk("b2b.lo2", lo, 32'd3);
    chk("b2b.hi2", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
